// File: rtl/pic_interrupt_sequencer_pkg.sv
// Shared types for the 8259A interrupt sequencer: FSM states, the 3-bit
// level type and the rotating-priority search helpers.
package pic_pkg;

    localparam int NUM_IRQ        = 8;
    localparam int SPURIOUS_LEVEL = 7;

    typedef logic [2:0] level_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_t;

    typedef struct packed {
        logic   found;
        level_t level;
    } pick_t;

    // Highest-priority set bit, where ptr is the lowest-priority level and
    // ptr+1 (mod 8) is the highest.
    function automatic pick_t highest_pick(input logic [NUM_IRQ-1:0] bits,
                                           input level_t             ptr);
        pick_t  r;
        level_t lvl;
        r = '0;
        for (int i = 1; i <= NUM_IRQ; i++) begin
            lvl = ptr + level_t'(i);
            if (!r.found && bits[lvl]) begin
                r.found = 1'b1;
                r.level = lvl;
            end
        end
        return r;
    endfunction

    // Priority rank of a level: 0 is the highest priority under this pointer.
    function automatic level_t prio_rank(input level_t lvl, input level_t ptr);
        return lvl - ptr - level_t'(1);
    endfunction

endpackage

// File: rtl/pic_interrupt_sequencer_if.sv
// Bus between the command/data-bus logic (master) and the interrupt
// sequencer (slave).
//
// Handshake: inta is a one-cycle strobe per INTA falling edge. The first
// strobe acknowledges the request and sets ISR; the second strobe makes the
// sequencer answer with exactly one vec_valid cycle carrying vec_data. There
// is no back-pressure: the consumer must take vec_data in that cycle.
// eoi_valid is likewise a one-cycle strobe and is accepted in every state.
interface pic_interrupt_sequencer_if;
    import pic_pkg::*;

    logic [NUM_IRQ-1:0] ir;
    logic [NUM_IRQ-1:0] imr;
    logic [4:0]         vec_base;
    logic               ltim;
    logic               aeoi;
    logic               eoi_valid;
    logic               eoi_specific;
    level_t             eoi_level;
    logic               eoi_rotate;
    logic               inta;
    logic               int_out;
    logic               vec_valid;
    logic [7:0]         vec_data;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;
    state_t             state;

    modport slave (
        input  ir, imr, vec_base, ltim, aeoi, eoi_valid, eoi_specific,
               eoi_level, eoi_rotate, inta,
        output int_out, vec_valid, vec_data, irr, isr, state
    );

    modport master (
        output ir, imr, vec_base, ltim, aeoi, eoi_valid, eoi_specific,
               eoi_level, eoi_rotate, inta,
        input  int_out, vec_valid, vec_data, irr, isr, state
    );

endinterface

// File: rtl/pic_interrupt_sequencer_resolver.sv
// Combinational priority resolver: picks the pending winner against the
// in-service levels (fully nested) and reports the highest in-service level
// for non-specific EOI.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    input  logic [NUM_IRQ-1:0] isr,
    input  level_t             ptr,
    output logic               win_valid,
    output level_t             win_level,
    output logic               isr_valid,
    output level_t             isr_level
);

    pick_t req_pick;
    pick_t isr_pick;

    // A request wins only if strictly higher priority than every ISR level.
    always_comb begin
        req_pick  = highest_pick(req, ptr);
        isr_pick  = highest_pick(isr, ptr);
        win_level = req_pick.level;
        isr_valid = isr_pick.found;
        isr_level = isr_pick.level;
        win_valid = req_pick.found &&
                    (!isr_pick.found ||
                     (prio_rank(req_pick.level, ptr) < prio_rank(isr_pick.level, ptr)));
    end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259A interrupt control core: IRR capture, priority resolution, INT, the
// two-pulse INTA sequence and EOI retirement.
// Optional feature: define PIC_ROTATE_EN for rotating priority; without it
// the lowest-priority pointer is fixed at 7 and eoi_rotate is ignored.
module pic_interrupt_sequencer
    import pic_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    pic_interrupt_sequencer_if.slave  bus
);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] ir_q, irr_q, isr_q, irr_d, req;
    logic [NUM_IRQ-1:0] ack_mask, eoi_mask, aeoi_mask;
    level_t             lvl_q, ptr, win_level, isr_level;
    logic               spur_q, int_q, vv_q, win_valid, isr_valid;
    logic               ack1_go, ack2_go;
    logic [7:0]         vd_q;

    assign req = irr_q & ~bus.imr;

    pic_priority_resolver u_resolver (
        .req       (req),
        .isr       (isr_q),
        .ptr       (ptr),
        .win_valid (win_valid),
        .win_level (win_level),
        .isr_valid (isr_valid),
        .isr_level (isr_level)
    );

`ifdef PIC_ROTATE_EN
    level_t ptr_q;

    // Lowest-priority pointer moves to the level retired by a rotating EOI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= level_t'(7);
        end else if (bus.eoi_valid && bus.eoi_rotate && (bus.eoi_specific || isr_valid)) begin
            ptr_q <= bus.eoi_specific ? bus.eoi_level : isr_level;
        end else if (ack2_go && bus.aeoi && !spur_q && bus.eoi_rotate) begin
            ptr_q <= lvl_q;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = level_t'(7);
`endif

    // INTA sequencing; an inta right after the vector cycle starts a new ACK1.
    always_comb begin
        state_d = state_q;
        ack1_go = 1'b0;
        ack2_go = 1'b0;
        case (state_q)
            IDLE: if (bus.inta) begin state_d = ACK1; ack1_go = 1'b1; end
            ACK1: if (bus.inta) begin state_d = ACK2; ack2_go = 1'b1; end
            ACK2: begin
                if (bus.inta) begin state_d = ACK1; ack1_go = 1'b1; end
                else          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Set/clear masks for IRR and ISR; EOI target uses ISR before the ACK1 set.
    always_comb begin
        ack_mask  = '0;
        eoi_mask  = '0;
        aeoi_mask = '0;
        if (ack1_go && win_valid) ack_mask[win_level] = 1'b1;
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) eoi_mask[bus.eoi_level] = 1'b1;
            else if (isr_valid)   eoi_mask[isr_level]     = 1'b1;
        end
        if (ack2_go && bus.aeoi && !spur_q) aeoi_mask[lvl_q] = 1'b1;
        if (bus.ltim) irr_d = bus.ir;
        else          irr_d = (irr_q | (bus.ir & ~ir_q)) & bus.ir;
    end

    // Registered state, request/service registers and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '1;
            irr_q   <= '0;
            isr_q   <= '0;
            lvl_q   <= level_t'(SPURIOUS_LEVEL);
            spur_q  <= 1'b0;
            int_q   <= 1'b0;
            vv_q    <= 1'b0;
            vd_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= bus.ir;
            irr_q   <= irr_d & ~ack_mask;
            isr_q   <= (isr_q & ~eoi_mask & ~aeoi_mask) | ack_mask;
            int_q   <= (state_d == IDLE) && win_valid;
            vv_q    <= ack2_go;
            if (ack1_go) begin
                lvl_q  <= win_valid ? win_level : level_t'(SPURIOUS_LEVEL);
                spur_q <= !win_valid;
            end
            if (ack2_go) vd_q <= {bus.vec_base, lvl_q};
        end
    end

    assign bus.int_out   = int_q;
    assign bus.vec_valid = vv_q;
    assign bus.vec_data  = vd_q;
    assign bus.irr       = irr_q;
    assign bus.isr       = isr_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed vector bench for pic_interrupt_sequencer.
module tb_pic_interrupt_sequencer;
    import pic_pkg::*;

    typedef struct {
        logic [7:0] ir;
        logic [7:0] imr;
        logic [3:0] ctl;    // {inta, eoi_valid, eoi_specific, eoi_rotate}
        logic [2:0] lvl;
        logic [1:0] x_iv;   // {int_out, vec_valid}
        logic [7:0] x_vd;
        logic [7:0] x_irr;
        logic [7:0] x_isr;
    } vec_t;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] INTA = 4'b1000;
    localparam logic [3:0] EOI  = 4'b0100;
    localparam logic [3:0] SEOI = 4'b0110;
    localparam logic [3:0] ROT  = 4'b0001;

`ifdef PIC_ROTATE_EN
    localparam logic [7:0] R_IRR = 8'h01;
    localparam logic [7:0] R_ISR = 8'h02;
    localparam logic [7:0] R_VD  = 8'h41;
`else
    localparam logic [7:0] R_IRR = 8'h02;
    localparam logic [7:0] R_ISR = 8'h01;
    localparam logic [7:0] R_VD  = 8'h40;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t tbl[$];

    pic_interrupt_sequencer_if bus();

    pic_interrupt_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [7:0] ir, input logic [7:0] imr,
                                input logic [3:0] ctl, input logic [2:0] lvl,
                                input logic [1:0] x_iv, input logic [7:0] x_vd,
                                input logic [7:0] x_irr, input logic [7:0] x_isr);
        vec_t v;
        v.ir = ir; v.imr = imr; v.ctl = ctl; v.lvl = lvl;
        v.x_iv = x_iv; v.x_vd = x_vd; v.x_irr = x_irr; v.x_isr = x_isr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input state_t exp);
        chk(name, {6'b0, bus.state}, {6'b0, exp});
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] x_iv, input logic [7:0] x_vd,
                            input logic [7:0] x_irr, input logic [7:0] x_isr);
        n_vec++;
        chk({tag, ".int_out"},   {7'b0, bus.int_out},   {7'b0, x_iv[1]});
        chk({tag, ".vec_valid"}, {7'b0, bus.vec_valid}, {7'b0, x_iv[0]});
        chk({tag, ".vec_data"},  bus.vec_data, x_vd);
        chk({tag, ".irr"},       bus.irr,      x_irr);
        chk({tag, ".isr"},       bus.isr,      x_isr);
    endtask

    // Drive one cycle of inputs, then check the registered result of that edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.ir  = v.ir;
        bus.imr = v.imr;
        {bus.inta, bus.eoi_valid, bus.eoi_specific, bus.eoi_rotate} = v.ctl;
        bus.eoi_level = v.lvl;
        @(posedge clk);
        #1;
        bus.inta      = 1'b0;
        bus.eoi_valid = 1'b0;
        chk_outs(tag, v.x_iv, v.x_vd, v.x_irr, v.x_isr);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.ir           = '0;
        bus.imr          = '0;
        bus.vec_base     = 5'h08;
        bus.ltim         = 1'b0;
        bus.aeoi         = 1'b0;
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_level    = '0;
        bus.eoi_rotate   = 1'b0;
        bus.inta         = 1'b0;

        // Edge-mode basic ACK, nesting, EOI forms and masking.
        tbl.push_back(mk(8'h00, 8'h00, NONE, 3'd0, 2'b00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(8'h08, 8'h00, NONE, 3'd0, 2'b00, 8'h00, 8'h08, 8'h00));
        tbl.push_back(mk(8'h08, 8'h00, NONE, 3'd0, 2'b10, 8'h00, 8'h08, 8'h00));
        tbl.push_back(mk(8'h08, 8'h00, INTA, 3'd0, 2'b00, 8'h00, 8'h00, 8'h08));
        tbl.push_back(mk(8'h08, 8'h00, NONE, 3'd0, 2'b00, 8'h00, 8'h00, 8'h08));
        tbl.push_back(mk(8'h00, 8'h00, INTA, 3'd0, 2'b01, 8'h43, 8'h00, 8'h08));
        tbl.push_back(mk(8'h00, 8'h00, NONE, 3'd0, 2'b00, 8'h43, 8'h00, 8'h08));
        tbl.push_back(mk(8'h00, 8'h00, EOI,  3'd0, 2'b00, 8'h43, 8'h00, 8'h00));
        tbl.push_back(mk(8'h20, 8'h00, NONE, 3'd0, 2'b00, 8'h43, 8'h20, 8'h00));
        tbl.push_back(mk(8'h20, 8'h00, NONE, 3'd0, 2'b10, 8'h43, 8'h20, 8'h00));
        tbl.push_back(mk(8'h20, 8'h00, INTA, 3'd0, 2'b00, 8'h43, 8'h00, 8'h20));
        tbl.push_back(mk(8'h20, 8'h20, NONE, 3'd0, 2'b00, 8'h43, 8'h00, 8'h20));
        tbl.push_back(mk(8'h20, 8'h00, INTA, 3'd0, 2'b01, 8'h45, 8'h00, 8'h20));
        tbl.push_back(mk(8'h20, 8'h00, NONE, 3'd0, 2'b00, 8'h45, 8'h00, 8'h20));
        tbl.push_back(mk(8'h24, 8'h00, NONE, 3'd0, 2'b00, 8'h45, 8'h04, 8'h20));
        tbl.push_back(mk(8'h24, 8'h00, NONE, 3'd0, 2'b10, 8'h45, 8'h04, 8'h20));
        tbl.push_back(mk(8'h24, 8'h00, INTA, 3'd0, 2'b00, 8'h45, 8'h00, 8'h24));
        tbl.push_back(mk(8'h24, 8'h00, NONE, 3'd0, 2'b00, 8'h45, 8'h00, 8'h24));
        tbl.push_back(mk(8'h24, 8'h00, INTA, 3'd0, 2'b01, 8'h42, 8'h00, 8'h24));
        tbl.push_back(mk(8'h24, 8'h00, NONE, 3'd0, 2'b00, 8'h42, 8'h00, 8'h24));
        tbl.push_back(mk(8'h64, 8'h00, NONE, 3'd0, 2'b00, 8'h42, 8'h40, 8'h24));
        tbl.push_back(mk(8'h64, 8'h00, NONE, 3'd0, 2'b00, 8'h42, 8'h40, 8'h24));
        tbl.push_back(mk(8'h64, 8'h00, EOI,  3'd0, 2'b00, 8'h42, 8'h40, 8'h20));
        tbl.push_back(mk(8'h64, 8'h00, NONE, 3'd0, 2'b00, 8'h42, 8'h40, 8'h20));
        tbl.push_back(mk(8'h64, 8'h00, EOI,  3'd0, 2'b00, 8'h42, 8'h40, 8'h00));
        tbl.push_back(mk(8'h64, 8'h00, NONE, 3'd0, 2'b10, 8'h42, 8'h40, 8'h00));
        tbl.push_back(mk(8'h64, 8'h00, INTA, 3'd0, 2'b00, 8'h42, 8'h00, 8'h40));
        tbl.push_back(mk(8'h64, 8'h00, NONE, 3'd0, 2'b00, 8'h42, 8'h00, 8'h40));
        tbl.push_back(mk(8'h64, 8'h00, INTA, 3'd0, 2'b01, 8'h46, 8'h00, 8'h40));
        tbl.push_back(mk(8'h64, 8'h00, SEOI, 3'd6, 2'b00, 8'h46, 8'h00, 8'h00));
        tbl.push_back(mk(8'h64, 8'h00, SEOI, 3'd3, 2'b00, 8'h46, 8'h00, 8'h00));
        tbl.push_back(mk(8'h00, 8'h00, NONE, 3'd0, 2'b00, 8'h46, 8'h00, 8'h00));
        tbl.push_back(mk(8'h02, 8'h02, NONE, 3'd0, 2'b00, 8'h46, 8'h02, 8'h00));
        tbl.push_back(mk(8'h02, 8'h02, NONE, 3'd0, 2'b00, 8'h46, 8'h02, 8'h00));
        tbl.push_back(mk(8'h02, 8'h00, NONE, 3'd0, 2'b10, 8'h46, 8'h02, 8'h00));
        tbl.push_back(mk(8'h00, 8'h00, NONE, 3'd0, 2'b10, 8'h46, 8'h00, 8'h00));
        tbl.push_back(mk(8'h00, 8'h00, NONE, 3'd0, 2'b00, 8'h46, 8'h00, 8'h00));

        // Reset values while reset is held.
        #12;
        chk_outs("reset", 2'b00, 8'h00, 8'h00, 8'h00);
        chk_state("reset.state", IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
            if (i == 3) chk_state("v3.state", ACK1);
        end

        // Spurious: request vanishes before the first INTA.
        apply(mk(8'h10, 8'h00, NONE, 3'd0, 2'b00, 8'h46, 8'h10, 8'h00), "spur0");
        apply(mk(8'h10, 8'h00, NONE, 3'd0, 2'b10, 8'h46, 8'h10, 8'h00), "spur1");
        apply(mk(8'h00, 8'h00, NONE, 3'd0, 2'b10, 8'h46, 8'h00, 8'h00), "spur2");
        apply(mk(8'h00, 8'h00, INTA, 3'd0, 2'b00, 8'h46, 8'h00, 8'h00), "spur3");
        chk_state("spur3.state", ACK1);
        apply(mk(8'h00, 8'h00, NONE, 3'd0, 2'b00, 8'h46, 8'h00, 8'h00), "spur4");
        apply(mk(8'h00, 8'h00, INTA, 3'd0, 2'b01, 8'h47, 8'h00, 8'h00), "spur5");
        apply(mk(8'h00, 8'h00, NONE, 3'd0, 2'b00, 8'h47, 8'h00, 8'h00), "spur6");

        // Auto-EOI in level mode with a persistent request.
        bus.ltim = 1'b1;
        bus.aeoi = 1'b1;
        apply(mk(8'h02, 8'h00, NONE, 3'd0, 2'b00, 8'h47, 8'h02, 8'h00), "aeoi0");
        apply(mk(8'h02, 8'h00, NONE, 3'd0, 2'b10, 8'h47, 8'h02, 8'h00), "aeoi1");
        apply(mk(8'h02, 8'h00, INTA, 3'd0, 2'b00, 8'h47, 8'h00, 8'h02), "aeoi2");
        apply(mk(8'h02, 8'h00, NONE, 3'd0, 2'b00, 8'h47, 8'h02, 8'h02), "aeoi3");
        apply(mk(8'h02, 8'h00, INTA, 3'd0, 2'b01, 8'h41, 8'h02, 8'h00), "aeoi4");
        apply(mk(8'h02, 8'h00, NONE, 3'd0, 2'b10, 8'h41, 8'h02, 8'h00), "aeoi5");
        apply(mk(8'h00, 8'h00, NONE, 3'd0, 2'b10, 8'h41, 8'h00, 8'h00), "aeoi6");
        apply(mk(8'h00, 8'h00, NONE, 3'd0, 2'b00, 8'h41, 8'h00, 8'h00), "aeoi7");
        bus.ltim = 1'b0;
        bus.aeoi = 1'b0;

        // Rotating EOI after servicing IR0 (fixed priority when not built in).
        apply(mk(8'h03, 8'h00, NONE,      3'd0, 2'b00, 8'h41, 8'h03, 8'h00), "rot1");
        apply(mk(8'h03, 8'h00, NONE,      3'd0, 2'b10, 8'h41, 8'h03, 8'h00), "rot2");
        apply(mk(8'h03, 8'h00, INTA,      3'd0, 2'b00, 8'h41, 8'h02, 8'h01), "rot3");
        apply(mk(8'h03, 8'h00, NONE,      3'd0, 2'b00, 8'h41, 8'h02, 8'h01), "rot4");
        apply(mk(8'h03, 8'h00, INTA,      3'd0, 2'b01, 8'h40, 8'h02, 8'h01), "rot5");
        apply(mk(8'h03, 8'h00, EOI | ROT, 3'd0, 2'b00, 8'h40, 8'h02, 8'h00), "rot6");
        apply(mk(8'h02, 8'h00, NONE,      3'd0, 2'b10, 8'h40, 8'h02, 8'h00), "rot7");
        apply(mk(8'h03, 8'h00, NONE,      3'd0, 2'b10, 8'h40, 8'h03, 8'h00), "rot8");
        apply(mk(8'h03, 8'h00, INTA,      3'd0, 2'b00, 8'h40, R_IRR, R_ISR), "rot9");
        apply(mk(8'h03, 8'h00, NONE,      3'd0, 2'b00, 8'h40, R_IRR, R_ISR), "rot10");
        apply(mk(8'h03, 8'h00, INTA,      3'd0, 2'b01, R_VD,  R_IRR, R_ISR), "rot11");
        apply(mk(8'h03, 8'h00, NONE,      3'd0, 2'b00, R_VD,  R_IRR, R_ISR), "rot12");
        apply(mk(8'h00, 8'h00, EOI,       3'd0, 2'b00, R_VD,  8'h00, 8'h00), "rot13");
        apply(mk(8'h00, 8'h00, NONE,      3'd0, 2'b00, R_VD,  8'h00, 8'h00), "rot14");

        // Asynchronous reset while in ACK1.
        apply(mk(8'h08, 8'h00, NONE, 3'd0, 2'b00, R_VD, 8'h08, 8'h00), "rst1");
        apply(mk(8'h08, 8'h00, NONE, 3'd0, 2'b10, R_VD, 8'h08, 8'h00), "rst2");
        apply(mk(8'h08, 8'h00, INTA, 3'd0, 2'b00, R_VD, 8'h00, 8'h08), "rst3");
        chk_state("rst3.state", ACK1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_async", 2'b00, 8'h00, 8'h00, 8'h00);
        chk_state("rst_async.state", IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(mk(8'h08, 8'h00, NONE, 3'd0, 2'b00, 8'h00, 8'h00, 8'h00),
                  $sformatf("post_rst%0d", k));
        end
        chk_state("post_rst.state", IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
